// File: rtl/l2_maxpool.sv
// 2x2 max-pool stage behind layer_2: reduces each group of four elements to its
// maximum and queues the result, tagged with channel and window, for the dense layer.
module l2_maxpool #(
   parameter int DW         = 18,
   parameter int N_WIN      = 25,
   parameter int FIFO_DEPTH = 8,
   localparam int IW        = $clog2(N_WIN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tx_done,
   input  logic          vld_in,
   input  logic [DW-1:0] din,
   output logic          stall,
   output logic          dout_vld,
   output logic [DW-1:0] dout,
   output logic [1:0]    dout_ch,
   output logic [IW-1:0] dout_idx,
   input  logic          rdy_in,
   output logic          frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    ch;
      logic [IW-1:0] idx;
   } entry_t;

   entry_t        mem [FIFO_DEPTH];
   entry_t        head;
   entry_t        wr_entry;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;

   logic [1:0]    cnt_e;
   logic [1:0]    cnt_ch;
   logic [IW-1:0] cnt_win;
   logic [DW-1:0] max_r;
   logic [DW-1:0] max_in;

   logic          accept;
   logic          push;
   logic          pop;

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign stall = full;

   // tx_done outranks both handshakes: nothing is accepted or popped while it is high.
   assign accept = vld_in && !full && !tx_done;
   assign push   = accept && (cnt_e == 2'd3);
   assign pop    = !empty && rdy_in && !tx_done;

   // The first element of a group replaces the running maximum instead of competing with it.
   assign max_in   = (cnt_e == 2'd0) ? din : ((din > max_r) ? din : max_r);
   assign wr_entry = '{data: max_in, ch: cnt_ch, idx: cnt_win};

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_e   <= '0;
         cnt_ch  <= '0;
         cnt_win <= '0;
         max_r   <= '0;
      end else if (tx_done) begin
         cnt_e   <= '0;
         cnt_ch  <= '0;
         cnt_win <= '0;
         max_r   <= '0;
      end else if (accept) begin
         max_r <= max_in;
         cnt_e <= cnt_e + 2'd1;
         if (cnt_e == 2'd3) begin
            cnt_ch <= cnt_ch + 2'd1;
            if (cnt_ch == 2'd3) begin
               cnt_win <= (cnt_win == IW'(N_WIN - 1)) ? '0 : cnt_win + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (tx_done) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; empty/valid come from the reset pointers, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head = mem[rd_ptr];

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      dout_vld = 1'b0;
      dout     = '0;
      dout_ch  = '0;
      dout_idx = '0;
      if (!empty) begin
         dout_vld = 1'b1;
         dout     = head.data;
         dout_ch  = head.ch;
         dout_idx = head.idx;
      end
   end

   // Pulses after the last channel of the last window leaves the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && (head.ch == 2'd3) && (head.idx == IW'(N_WIN - 1));
      end
   end

endmodule
